enigma_controller: RTL and testbench

Sequencer for the single-rotor Enigma datapath (rotor plus letter shifter). It accepts ASCII characters over a valid/ready handshake and folds lowercase to uppercase. For each letter it issues one rotor step pulse, waits for the datapath to settle, captures the result and presents it downstream over valid/ready. It also owns rotor configuration: the init-state load sequence on request and automatically after reset. It keeps a shadow rotor position for display.

---
 rtl/enigma_pkg.sv | 28 ++
 rtl/ascii_letter_classifier.sv | 21 ++
 rtl/enigma_controller.sv | 201 ++++++++++++++++++++
 tb/tb_enigma_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared constants, controller state encoding and helpers for the Enigma sequencer.
`timescale 1ns/1ps
package enigma_pkg;

    localparam int unsigned ALPHABET_SIZE = 26;

    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_Z     = 8'h5A;
    localparam logic [7:0] ASCII_LA    = 8'h61;
    localparam logic [7:0] ASCII_LZ    = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    typedef enum logic [2:0] {
        StInit,
        StLdSet,
        StLdClk,
        StLdHold,
        StIdle,
        StStep,
        StSettle,
        StOut
    } ctrl_state_e;

    function automatic logic [4:0] rotor_inc(input logic [4:0] pos);
        return (pos == 5'(ALPHABET_SIZE - 1)) ? 5'd0 : pos + 5'd1;
    endfunction

endpackage

// File: rtl/ascii_letter_classifier.sv
// Combinational ASCII letter detector with lowercase-to-uppercase folding.
`timescale 1ns/1ps
module ascii_letter_classifier
    import enigma_pkg::*;
(
    input  logic [7:0] char_i,
    output logic       is_letter_o,
    output logic [7:0] folded_char_o
);

    logic is_upper;
    logic is_lower;

    always_comb begin
        is_upper      = (char_i >= ASCII_A)  && (char_i <= ASCII_Z);
        is_lower      = (char_i >= ASCII_LA) && (char_i <= ASCII_LZ);
        is_letter_o   = is_upper || is_lower;
        folded_char_o = is_lower ? (char_i - CASE_OFFSET) : char_i;
    end

endmodule

// File: rtl/enigma_controller.sv
// Sequencer for the single-rotor Enigma datapath: input handshake, rotor stepping and
// settling, result capture, rotor init-state loading and a shadow rotor position.
`timescale 1ns/1ps
module enigma_controller
    import enigma_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          PASS_NONALPHA = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  in_char_i,
    input  logic        in_encrypt_i,
    input  logic        cfg_load_i,
    input  logic [4:0]  cfg_state_i,
    output logic        cfg_err_o,
    output logic [7:0]  enc_char_o,
    output logic        enc_encrypt_o,
    output logic        enc_step_o,
    output logic        enc_load_o,
    output logic [4:0]  enc_init_state_o,
    input  logic [7:0]  enc_letter_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [7:0]  out_char_o,
    output logic [4:0]  rotor_pos_o,
    output logic [15:0] char_count_o,
    output logic        busy_o
);

    ctrl_state_e state_q, state_d;

    logic [7:0]  enc_char_q, enc_char_d;
    logic        enc_encrypt_q, enc_encrypt_d;
    logic [4:0]  enc_init_state_q, enc_init_state_d;
    logic [7:0]  out_char_q, out_char_d;
    logic [4:0]  rotor_pos_q, rotor_pos_d;
    logic [15:0] char_count_q, char_count_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic        cfg_err_q, cfg_err_d;

    logic       is_letter;
    logic [7:0] folded_char;
    logic       cfg_ok;
    logic       idle_cfg;
    logic       accept;

    ascii_letter_classifier u_classifier (
        .char_i        (in_char_i),
        .is_letter_o   (is_letter),
        .folded_char_o (folded_char)
    );

    assign cfg_ok   = (cfg_state_i < 5'(ALPHABET_SIZE));
    assign idle_cfg = (state_q == StIdle) && cfg_load_i;
    assign accept   = in_valid_i && in_ready_o;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a pending cfg_load shadows any offered character
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:   state_d = StLdSet;
            StLdSet:  state_d = StLdClk;
            StLdClk:  state_d = StLdHold;
            StLdHold: state_d = StIdle;
            StIdle: begin
                if (cfg_load_i) begin
                    if (cfg_ok) begin
                        state_d = StLdSet;
                    end
                end else if (in_valid_i) begin
                    if (is_letter) begin
                        state_d = StStep;
                    end else if (PASS_NONALPHA) begin
                        state_d = StOut;
                    end
                end
            end
            StStep:   state_d = StSettle;
            StSettle: begin
                if (settle_cnt_q == 4'd0) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default:  state_d = StInit;
        endcase
    end

    // Moore-style handshake and datapath strobes
    always_comb begin
        enc_step_o  = 1'b0;
        enc_load_o  = 1'b0;
        out_valid_o = 1'b0;
        in_ready_o  = 1'b0;
        unique case (state_q)
            StLdSet:  enc_load_o = 1'b1;
            StLdClk: begin
                enc_load_o = 1'b1;
                enc_step_o = 1'b1;
            end
            StLdHold: enc_load_o = 1'b1;
            StIdle:   in_ready_o = !cfg_load_i;
            StStep:   enc_step_o = 1'b1;
            StOut:    out_valid_o = 1'b1;
            default: ;
        endcase
        busy_o = (state_q != StIdle);
    end

    // Datapath register next-state
    always_comb begin
        enc_char_d       = enc_char_q;
        enc_encrypt_d    = enc_encrypt_q;
        enc_init_state_d = enc_init_state_q;
        out_char_d       = out_char_q;
        rotor_pos_d      = rotor_pos_q;
        char_count_d     = char_count_q;
        settle_cnt_d     = settle_cnt_q;
        cfg_err_d        = 1'b0;

        unique case (state_q)
            StInit:   enc_init_state_d = 5'd0;
            StLdHold: rotor_pos_d = enc_init_state_q;
            StIdle: begin
                if (idle_cfg) begin
                    if (cfg_ok) begin
                        enc_init_state_d = cfg_state_i;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if (accept) begin
                    enc_char_d    = folded_char;
                    enc_encrypt_d = in_encrypt_i;
                    if (!is_letter && PASS_NONALPHA) begin
                        out_char_d = in_char_i;
                    end
                end
            end
            StStep: begin
                rotor_pos_d  = rotor_inc(rotor_pos_q);
                char_count_d = char_count_q + 16'd1;
                settle_cnt_d = 4'(SETTLE_CYCLES - 1);
            end
            StSettle: begin
                if (settle_cnt_q == 4'd0) begin
                    out_char_d = enc_letter_i;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            enc_char_q       <= 8'd0;
            enc_encrypt_q    <= 1'b0;
            enc_init_state_q <= 5'd0;
            out_char_q       <= 8'd0;
            rotor_pos_q      <= 5'd0;
            char_count_q     <= 16'd0;
            settle_cnt_q     <= 4'd0;
            cfg_err_q        <= 1'b0;
        end else begin
            enc_char_q       <= enc_char_d;
            enc_encrypt_q    <= enc_encrypt_d;
            enc_init_state_q <= enc_init_state_d;
            out_char_q       <= out_char_d;
            rotor_pos_q      <= rotor_pos_d;
            char_count_q     <= char_count_d;
            settle_cnt_q     <= settle_cnt_d;
            cfg_err_q        <= cfg_err_d;
        end
    end

    assign enc_char_o       = enc_char_q;
    assign enc_encrypt_o    = enc_encrypt_q;
    assign enc_init_state_o = enc_init_state_q;
    assign out_char_o       = out_char_q;
    assign rotor_pos_o      = rotor_pos_q;
    assign char_count_o     = char_count_q;
    assign cfg_err_o        = cfg_err_q;

endmodule

// File: tb/tb_enigma_controller.sv
// Directed bench for enigma_controller against a one-rotor Caesar-shift datapath stub.
`timescale 1ns/1ps
module tb_enigma_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_encrypt = 1'b0, cfg_load = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_char = 8'h00;
    logic [4:0]  cfg_state = 5'd0;
    logic        in_ready, cfg_err, enc_encrypt, enc_step, enc_load, out_valid, busy;
    logic [7:0]  enc_char, enc_letter, out_char;
    logic [4:0]  enc_init_state, rotor_pos;
    logic [15:0] char_count;

    // Second instance exercising the drop-non-letters variant
    logic        in_valid2 = 1'b0;
    logic [7:0]  in_char2 = 8'h00;
    logic [7:0]  enc_letter2 = 8'h00;
    logic        in_ready2, cfg_err2, enc_encrypt2, enc_step2, enc_load2, out_valid2, busy2;
    logic [7:0]  enc_char2, out_char2;
    logic [4:0]  enc_init_state2, rotor_pos2;
    logic [15:0] char_count2;

    int n_vec = 0;
    int n_err = 0;
    int steps = 0;
    logic [4:0] stub_rot;

    enigma_controller #(.SETTLE_CYCLES(2), .PASS_NONALPHA(1'b1)) dut (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_char_i(in_char), .in_encrypt_i(in_encrypt), .cfg_load_i(cfg_load),
        .cfg_state_i(cfg_state), .cfg_err_o(cfg_err), .enc_char_o(enc_char),
        .enc_encrypt_o(enc_encrypt), .enc_step_o(enc_step), .enc_load_o(enc_load),
        .enc_init_state_o(enc_init_state), .enc_letter_i(enc_letter),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_char_o(out_char),
        .rotor_pos_o(rotor_pos), .char_count_o(char_count), .busy_o(busy)
    );

    enigma_controller #(.SETTLE_CYCLES(2), .PASS_NONALPHA(1'b0)) dut_drop (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
        .in_char_i(in_char2), .in_encrypt_i(1'b1), .cfg_load_i(1'b0),
        .cfg_state_i(5'd0), .cfg_err_o(cfg_err2), .enc_char_o(enc_char2),
        .enc_encrypt_o(enc_encrypt2), .enc_step_o(enc_step2), .enc_load_o(enc_load2),
        .enc_init_state_o(enc_init_state2), .enc_letter_i(enc_letter2),
        .out_valid_o(out_valid2), .out_ready_i(1'b1), .out_char_o(out_char2),
        .rotor_pos_o(rotor_pos2), .char_count_o(char_count2), .busy_o(busy2)
    );

    // Datapath stub: rotor loads on step-with-load, otherwise advances mod 26
    always @(posedge clk) begin
        if (reset) stub_rot <= 5'd0;
        else if (enc_step) stub_rot <= enc_load ? enc_init_state
                                     : ((stub_rot == 5'd25) ? 5'd0 : stub_rot + 5'd1);
    end

    always @(posedge clk) if (enc_step) steps <= steps + 1;

    function automatic logic [7:0] stub_letter(input logic [7:0] c, input logic [4:0] r);
        int v;
        v = (int'(c) - 65 + int'(r)) % 26;
        if (v < 0) v += 26;
        return 8'(65 + v);
    endfunction

    assign enc_letter = stub_letter(enc_char, stub_rot);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one character and wait (bounded) for the result; returns in the first OUT cycle
    task automatic run_char(input string tag, input logic [7:0] ch, input logic enc,
                            input logic [7:0] exp_char, input int exp_lat);
        int lat;
        in_valid = 1'b1; in_char = ch; in_encrypt = enc;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_out_char"}, out_char, exp_char);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        check_eq({tag, "_out_valid_drop"}, out_valid, 1'b0);
        check_eq({tag, "_in_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        int s0;
        logic ok;

        // Reset state
        reset = 1'b1;
        tick(); tick();
        check_eq("rst_enc_step", enc_step, 1'b0);
        check_eq("rst_enc_load", enc_load, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_rotor_pos", rotor_pos, 5'd0);
        check_eq("rst_char_count", char_count, 16'd0);
        check_eq("rst_cfg_err", cfg_err, 1'b0);
        check_eq("rst_out_char", out_char, 8'h00);

        // Automatic load to 0 after reset
        s0 = steps;
        reset = 1'b0;
        tick();
        check_eq("ld_set", {enc_load, enc_step, 3'b0, enc_init_state}, {2'b10, 3'b0, 5'd0});
        tick();
        check_eq("ld_clk", {enc_load, enc_step}, 2'b11);
        tick();
        check_eq("ld_hold", {enc_load, enc_step}, 2'b10);
        tick();
        check_eq("idle_in_ready_c4", in_ready, 1'b1);
        check_eq("idle_enc_load", enc_load, 1'b0);
        check_eq("idle_rotor_pos", rotor_pos, 5'd0);
        check_eq("init_step_count", steps - s0, 1);

        // Lowercase letter: folded, stepped once, shifted by the new rotor position
        s0 = steps;
        in_valid = 1'b1; in_char = 8'h61; in_encrypt = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("a_enc_step_c1", enc_step, 1'b1);
        check_eq("a_enc_char", enc_char, 8'h41);
        check_eq("a_enc_encrypt", enc_encrypt, 1'b1);
        tick(); tick();
        check_eq("a_out_valid_c3", out_valid, 1'b0);
        tick();
        check_eq("a_out_valid_c4", out_valid, 1'b1);
        check_eq("a_out_char", out_char, 8'h42);
        check_eq("a_rotor_pos", rotor_pos, 5'd1);
        check_eq("a_char_count", char_count, 16'd1);
        drain("a");
        check_eq("a_step_count", steps - s0, 1);

        // Load position 25, then 'Z' wraps the rotor to 0
        s0 = steps;
        cfg_load = 1'b1; cfg_state = 5'd25;
        #1;
        check_eq("cfg_in_ready_low", in_ready, 1'b0);
        tick();
        cfg_load = 1'b0;
        check_eq("cfg25_ld", {enc_load, 3'b0, enc_init_state}, {1'b1, 3'b0, 5'd25});
        tick(); tick(); tick();
        check_eq("cfg25_rotor_pos", rotor_pos, 5'd25);
        check_eq("cfg25_steps", steps - s0, 1);
        run_char("Z", 8'h5A, 1'b0, 8'h5A, 4);
        check_eq("Z_rotor_wrap", rotor_pos, 5'd0);
        check_eq("Z_enc_encrypt", enc_encrypt, 1'b0);
        drain("Z");

        // Out-of-range load request
        cfg_load = 1'b1; cfg_state = 5'd26;
        tick();
        cfg_load = 1'b0;
        check_eq("cfg26_err", cfg_err, 1'b1);
        check_eq("cfg26_no_load", {enc_load, busy}, 2'b00);
        tick();
        check_eq("cfg26_err_pulse", cfg_err, 1'b0);
        check_eq("cfg26_rotor_pos", rotor_pos, 5'd0);

        // Non-letter pass-through
        s0 = steps;
        run_char("space", 8'h20, 1'b1, 8'h20, 1);
        drain("space");
        check_eq("space_no_step", steps - s0, 0);
        check_eq("space_char_count", char_count, 16'd2);

        // Non-letter dropped by the other variant
        in_valid2 = 1'b1; in_char2 = 8'h20;
        #1;
        check_eq("drop_in_ready", in_ready2, 1'b1);
        tick();
        in_valid2 = 1'b0;
        check_eq("drop_no_valid", out_valid2, 1'b0);
        check_eq("drop_in_ready_next", in_ready2, 1'b1);
        tick();
        check_eq("drop_still_no_valid", {out_valid2, enc_step2, char_count2}, 18'd0);

        // Back-pressure in OUT
        out_ready = 1'b0;
        run_char("bp", 8'h43, 1'b1, 8'h44, 4);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(out_valid && out_char == 8'h44 && !in_ready)) ok = 1'b0;
        end
        check_eq("bp_hold_stable", ok, 1'b1);
        drain("bp");

        // cfg_load and in_valid together: load wins, char accepted afterwards
        cfg_load = 1'b1; cfg_state = 5'd3;
        in_valid = 1'b1; in_char = 8'h42; in_encrypt = 1'b1;
        #1;
        check_eq("both_in_ready", in_ready, 1'b0);
        tick();
        cfg_load = 1'b0;
        check_eq("both_load_taken", enc_load, 1'b1);
        tick(); tick(); tick();
        check_eq("both_idle_ready", in_ready, 1'b1);
        check_eq("both_rotor_pos", rotor_pos, 5'd3);
        tick();
        in_valid = 1'b0;
        check_eq("both_step", enc_step, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = out_valid;
        end
        check_eq("both_out_valid", ok, 1'b1);
        check_eq("both_out_char", out_char, 8'h46);
        check_eq("both_char_count", char_count, 16'd4);
        drain("both");

        // Reset while settling discards the character and reloads
        in_valid = 1'b1; in_char = 8'h41;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_eq("rs_outputs",
                 {enc_step, enc_load, out_valid, in_ready, cfg_err, rotor_pos, char_count},
                 26'd0);
        s0 = steps;
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) ok = 1'b0;
        end
        check_eq("rs_no_out_valid", ok, 1'b1);
        check_eq("rs_reload_steps", steps - s0, 1);
        check_eq("rs_idle_ready", in_ready, 1'b1);
        check_eq("rs_rotor_count", {rotor_pos, char_count}, 21'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
